multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Moore/Mealy control FSM for the unpipelined multicycle MIPS core. It sequences one shared ALU, one unified instruction/data memory and the register-file/decode stage across Fetch, Decode, Execute, Memory and Writeback cycles. It drives every datapath control signal, including the decode stage's register-destination select and register-file write enable, from the IR opcode/funct, the ALU zero flag and a memory ready handshake. It also flags illegal instructions and counts retired instructions.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- i_clk  in  1  rising-edge clock
- i_rst  in  1  synchronous, active-high reset
- i_opcode  in  6  IR[31:26]; valid from DECODE onward
- i_funct  in  6  IR[5:0]
- i_zero  in  1  ALU zero flag, same-cycle
- i_mem_ready  in  1  memory completes access this cycle
- o_c_pcWrite  out  1  PC load enable
- o_c_irWrite  out  1  IR load enable
- o_c_iorD  out  1  memory address: 0=PC, 1=ALUOut
- o_c_memRead  out  1  memory read request
- o_c_memWrite  out  1  memory write request
- o_c_memToReg  out  1  writeback data: 0=ALUOut, 1=MDR
- o_c_regDst  out  1  write address: 0=Rt, 1=Rd
- o_c_regWrite  out  1  register-file write enable
- o_c_aluSrcA  out  1  0=PC, 1=regA
- o_c_aluSrcB  out  2  00=regB, 01=const 4, 10=sext imm, 11=sext imm<<2
- o_c_aluOp  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt
- o_c_pcSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
- o_state  out  4  current state encoding
- o_illegal  out  1  sticky illegal-instruction flag
- o_instr_cnt  out  CNT_W  retired instructions, wraps

## Operation
- States, with encodings: FETCH=0, DECODE=1, EXEC_R=2, ADDR=3, MEM_RD=4, WB_LD=5, MEM_WR=6, WB_R=7, WB_I=8, BRANCH=9, JUMP=10, TRAP=11.
- Any output not listed for a state is 0.
- FETCH:
  - Outputs: memRead=1, iorD=0, aluSrcA=0, aluSrcB=01, aluOp=add, pcSrc=00.
  - irWrite and pcWrite equal i_mem_ready (Mealy).
  - Hold in FETCH until i_mem_ready, then go to DECODE.
- DECODE:
  - Outputs: aluSrcA=0, aluSrcB=11, aluOp=add, which precomputes the branch target into ALUOut.
  - Next state by opcode:
    - 0x00 → EXEC_R
    - 0x23 (lw), 0x2B (sw), 0x08 (addi) → ADDR
    - 0x04 (beq) → BRANCH
    - 0x02 (j) → JUMP
    - any other opcode → TRAP
- EXEC_R:
  - Outputs: aluSrcA=1, aluSrcB=00.
  - aluOp by funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
  - Other funct values → TRAP; otherwise → WB_R.
- ADDR:
  - Outputs: aluSrcA=1, aluSrcB=10, aluOp=add.
  - Next state: lw → MEM_RD, sw → MEM_WR, addi → WB_I.
- MEM_RD: memRead=1, iorD=1. Hold until i_mem_ready, then → WB_LD.
- MEM_WR: memWrite=1, iorD=1. Hold until i_mem_ready, then → FETCH (retire).
- WB_R: regDst=1, regWrite=1, memToReg=0 → FETCH (retire).
- WB_I: regDst=0, regWrite=1, memToReg=0 → FETCH (retire).
- WB_LD: regDst=0, regWrite=1, memToReg=1 → FETCH (retire).
- BRANCH:
  - Outputs: aluSrcA=1, aluSrcB=00, aluOp=sub, pcSrc=01.
  - pcWrite equals i_zero (Mealy).
  - → FETCH (retire, whether taken or not).
- JUMP: pcSrc=10, pcWrite=1 → FETCH (retire).
- TRAP:
  - All control outputs 0; o_illegal=1.
  - Absorbing; only i_rst exits.
- Counter:
  - o_instr_cnt increments by 1 on every retire transition.
  - Wraps modulo 2^CNT_W.
  - Never increments on the transition into TRAP.

## Timing
- Reset values, on the rising edge with i_rst=1: state=FETCH, o_illegal=0, o_instr_cnt=0.
- While i_rst=1, all o_c_* outputs are forced to 0 combinationally. A reset asserted mid-MEM_WR therefore drops memWrite in that same cycle.
- The first cycle after i_rst deasserts is FETCH.
- Latency with zero wait states (i_mem_ready=1 throughout):
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- Each cycle with i_mem_ready=0 in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- During a memory stall, all other outputs stay constant.
- i_mem_ready is ignored outside FETCH, MEM_RD and MEM_WR.
- i_opcode and i_funct are sampled only in DECODE and EXEC_R. IR changes in any other state have no effect.
- o_state, o_illegal and o_instr_cnt are registered. Mealy outputs are irWrite, pcWrite and the EXEC_R aluOp.

## Test plan
- Reset then R-type add (op 0x00, funct 0x20), ready=1:
  - Required state sequence: 0,1,2,7,0.
  - WB_R cycle: regDst=1, regWrite=1.
  - o_instr_cnt: 0→1.
- lw (op 0x23) with ready low for 2 cycles in MEM_RD:
  - MEM_RD lasts 3 cycles with memRead=1 and iorD=1.
  - WB_LD has memToReg=1, regDst=0; 7 cycles total.
- beq (op 0x04):
  - With i_zero=1: pcWrite=1 and pcSrc=01 in BRANCH.
  - With i_zero=0: pcWrite=0.
  - Both cases retire after 3 cycles.
- Illegal funct 0x3F under op 0x00:
  - EXEC_R → TRAP; o_illegal=1 persists for 10+ cycles; o_instr_cnt unchanged.
  - Asserting i_rst clears o_illegal to 0 and returns state to 0.
- sw (op 0x2B) with i_rst asserted during MEM_WR:
  - memWrite=0 in the reset cycle.
  - Next cycle: state=FETCH, o_instr_cnt=0.
- Counter wrap with CNT_W=4: run 16 j instructions → o_instr_cnt returns to 0.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: control FSM for an unpipelined multicycle MIPS core.
// It sequences Fetch/Decode/Execute/Memory/Writeback over a shared ALU and a
// unified memory. It also flags illegal instructions and counts retired
// instructions.
//
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_opcode, i_funct      IR fields, sampled only in DECODE / EXEC_R
//   i_zero                 ALU zero flag, used in BRANCH
//   i_mem_ready            memory access completes this cycle
//   o_c_*                  datapath control signals; all 0 while i_rst=1
//   o_state                current state encoding
//   o_illegal              sticky illegal-instruction flag
//   o_instr_cnt            retired-instruction counter, wraps
module multicycle_ctrl #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [5:0]       i_opcode,
    input  logic [5:0]       i_funct,
    input  logic             i_zero,
    input  logic             i_mem_ready,
    output logic             o_c_pcWrite,
    output logic             o_c_irWrite,
    output logic             o_c_iorD,
    output logic             o_c_memRead,
    output logic             o_c_memWrite,
    output logic             o_c_memToReg,
    output logic             o_c_regDst,
    output logic             o_c_regWrite,
    output logic             o_c_aluSrcA,
    output logic [1:0]       o_c_aluSrcB,
    output logic [3:0]       o_c_aluOp,
    output logic [1:0]       o_c_pcSrc,
    output logic [3:0]       o_state,
    output logic             o_illegal,
    output logic [CNT_W-1:0] o_instr_cnt
);

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StExecR  = 4'd2,
        StAddr   = 4'd3,
        StMemRd  = 4'd4,
        StWbLd   = 4'd5,
        StMemWr  = 4'd6,
        StWbR    = 4'd7,
        StWbI    = 4'd8,
        StBranch = 4'd9,
        StJump   = 4'd10,
        StTrap   = 4'd11
    } state_t;

    // Which memory-class instruction ADDR is serving; latched in DECODE so
    // later IR changes cannot redirect it.
    typedef enum logic [1:0] {KindLw, KindSw, KindAddi} kind_t;

    localparam logic [3:0] AluAdd = 4'b0010;
    localparam logic [3:0] AluSub = 4'b0110;
    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluOr  = 4'b0001;
    localparam logic [3:0] AluSlt = 4'b0111;

    state_t            state_q, state_d;
    kind_t             kind_q, kind_d;
    logic              illegal_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              retire;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StFetch;
            kind_q    <= KindAddi;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            if (state_d == StTrap) begin
                illegal_q <= 1'b1;
            end
            if (retire) begin
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        kind_d       = kind_q;
        retire       = 1'b0;
        o_c_pcWrite  = 1'b0;
        o_c_irWrite  = 1'b0;
        o_c_iorD     = 1'b0;
        o_c_memRead  = 1'b0;
        o_c_memWrite = 1'b0;
        o_c_memToReg = 1'b0;
        o_c_regDst   = 1'b0;
        o_c_regWrite = 1'b0;
        o_c_aluSrcA  = 1'b0;
        o_c_aluSrcB  = 2'b00;
        o_c_aluOp    = 4'b0000;
        o_c_pcSrc    = 2'b00;

        unique case (state_q)
            StFetch: begin
                o_c_memRead = 1'b1;
                o_c_aluSrcB = 2'b01;
                o_c_aluOp   = AluAdd;
                o_c_irWrite = i_mem_ready;
                o_c_pcWrite = i_mem_ready;
                if (i_mem_ready) state_d = StDecode;
            end
            StDecode: begin
                // Branch target precomputed into ALUOut.
                o_c_aluSrcB = 2'b11;
                o_c_aluOp   = AluAdd;
                unique case (i_opcode)
                    6'h00:   state_d = StExecR;
                    6'h23:   begin state_d = StAddr; kind_d = KindLw;   end
                    6'h2B:   begin state_d = StAddr; kind_d = KindSw;   end
                    6'h08:   begin state_d = StAddr; kind_d = KindAddi; end
                    6'h04:   state_d = StBranch;
                    6'h02:   state_d = StJump;
                    default: state_d = StTrap;
                endcase
            end
            StExecR: begin
                o_c_aluSrcA = 1'b1;
                state_d     = StWbR;
                unique case (i_funct)
                    6'h20:   o_c_aluOp = AluAdd;
                    6'h22:   o_c_aluOp = AluSub;
                    6'h24:   o_c_aluOp = AluAnd;
                    6'h25:   o_c_aluOp = AluOr;
                    6'h2A:   o_c_aluOp = AluSlt;
                    default: state_d   = StTrap;
                endcase
            end
            StAddr: begin
                o_c_aluSrcA = 1'b1;
                o_c_aluSrcB = 2'b10;
                o_c_aluOp   = AluAdd;
                unique case (kind_q)
                    KindLw:  state_d = StMemRd;
                    KindSw:  state_d = StMemWr;
                    default: state_d = StWbI;
                endcase
            end
            StMemRd: begin
                o_c_memRead = 1'b1;
                o_c_iorD    = 1'b1;
                if (i_mem_ready) state_d = StWbLd;
            end
            StMemWr: begin
                o_c_memWrite = 1'b1;
                o_c_iorD     = 1'b1;
                if (i_mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end
            StWbR: begin
                o_c_regDst   = 1'b1;
                o_c_regWrite = 1'b1;
                state_d      = StFetch;
                retire       = 1'b1;
            end
            StWbI: begin
                o_c_regWrite = 1'b1;
                state_d      = StFetch;
                retire       = 1'b1;
            end
            StWbLd: begin
                o_c_regWrite = 1'b1;
                o_c_memToReg = 1'b1;
                state_d      = StFetch;
                retire       = 1'b1;
            end
            StBranch: begin
                o_c_aluSrcA = 1'b1;
                o_c_aluOp   = AluSub;
                o_c_pcSrc   = 2'b01;
                o_c_pcWrite = i_zero;
                state_d     = StFetch;
                retire      = 1'b1;
            end
            StJump: begin
                o_c_pcSrc   = 2'b10;
                o_c_pcWrite = 1'b1;
                state_d     = StFetch;
                retire      = 1'b1;
            end
            StTrap:  state_d = StTrap;
            default: state_d = StTrap;
        endcase

        // Controls are quiet during reset so no memory write can complete.
        if (i_rst) begin
            o_c_pcWrite  = 1'b0;
            o_c_irWrite  = 1'b0;
            o_c_iorD     = 1'b0;
            o_c_memRead  = 1'b0;
            o_c_memWrite = 1'b0;
            o_c_memToReg = 1'b0;
            o_c_regDst   = 1'b0;
            o_c_regWrite = 1'b0;
            o_c_aluSrcA  = 1'b0;
            o_c_aluSrcB  = 2'b00;
            o_c_aluOp    = 4'b0000;
            o_c_pcSrc    = 2'b00;
        end
    end

    assign o_state     = state_q;
    assign o_illegal   = illegal_q;
    assign o_instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       opcode, funct;
    logic             zero, ready;
    logic             pc_write, ir_write, ior_d, mem_read, mem_write, mem_to_reg;
    logic             reg_dst, reg_write, alu_src_a;
    logic [1:0]       alu_src_b, pc_src;
    logic [3:0]       alu_op, state;
    logic             illegal;
    logic [CNT_W-1:0] cnt;
    logic [16:0]      ctrl_vec;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    multicycle_ctrl #(.CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst(rst), .i_opcode(opcode), .i_funct(funct),
        .i_zero(zero), .i_mem_ready(ready),
        .o_c_pcWrite(pc_write), .o_c_irWrite(ir_write), .o_c_iorD(ior_d),
        .o_c_memRead(mem_read), .o_c_memWrite(mem_write), .o_c_memToReg(mem_to_reg),
        .o_c_regDst(reg_dst), .o_c_regWrite(reg_write), .o_c_aluSrcA(alu_src_a),
        .o_c_aluSrcB(alu_src_b), .o_c_aluOp(alu_op), .o_c_pcSrc(pc_src),
        .o_state(state), .o_illegal(illegal), .o_instr_cnt(cnt)
    );

    always #5 clk = ~clk;

    assign ctrl_vec = {pc_write, ir_write, ior_d, mem_read, mem_write, mem_to_reg,
                       reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_src};

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic bit funct_legal(input logic [5:0] fn);
        return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
    endfunction

    // Control word per state, straight from the state/output table.
    function automatic logic [16:0] exp_ctrl(input int st, input logic rdy, input logic z,
                                             input logic [5:0] fn);
        logic pcw, irw, iord, mrd, mwr, m2r, rdst, rwr, sa;
        logic [1:0] sb, ps;
        logic [3:0] op;
        {pcw, irw, iord, mrd, mwr, m2r, rdst, rwr, sa} = '0;
        sb = 2'b00; ps = 2'b00; op = 4'b0000;
        case (st)
            0:  begin mrd = 1; sb = 2'b01; op = 4'b0010; irw = rdy; pcw = rdy; end
            1:  begin sb = 2'b11; op = 4'b0010; end
            2:  begin sa = 1; op = funct_alu(fn); end
            3:  begin sa = 1; sb = 2'b10; op = 4'b0010; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rwr = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin rdst = 1; rwr = 1; end
            8:  begin rwr = 1; end
            9:  begin sa = 1; op = 4'b0110; ps = 2'b01; pcw = z; end
            10: begin ps = 2'b10; pcw = 1; end
            default: ;
        endcase
        return {pcw, irw, iord, mrd, mwr, m2r, rdst, rwr, sa, sb, op, ps};
    endfunction

    // One clock cycle in which the DUT should sit in state est. Entered and
    // left at posedge+1. The IR is scrambled outside DECODE/EXEC_R.
    task automatic cycle(input int est, input logic rdy, input logic [5:0] op,
                         input logic [5:0] fn, input logic z);
        ready = rdy;
        zero  = z;
        if (est == 1 || est == 2) begin
            opcode = op;
            funct  = fn;
        end else begin
            opcode = 6'($urandom);
            funct  = 6'($urandom);
        end
        @(negedge clk);
        check("state", int'(state), est);
        check("ctrl", int'(ctrl_vec), int'(exp_ctrl(est, rdy, z, fn)));
        check("illegal", int'(illegal), (est == 11) ? 1 : 0);
        check("instr_cnt", int'(cnt), exp_cnt);
        @(posedge clk);
        #1;
    endtask

    // Instruction-level model: build the expected state walk for this
    // instruction with its planned memory stalls, then replay and compare.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int sf, input int sm);
        int   st_q[$];
        logic rd_q[$];
        bit   trap = 0;
        for (int i = 0; i < sf; i++) begin st_q.push_back(0); rd_q.push_back(0); end
        st_q.push_back(0); rd_q.push_back(1);
        st_q.push_back(1); rd_q.push_back(1'($urandom));
        case (op)
            6'h00: begin
                st_q.push_back(2); rd_q.push_back(1'($urandom));
                trap = !funct_legal(fn);
                st_q.push_back(trap ? 11 : 7); rd_q.push_back(1'($urandom));
            end
            6'h23, 6'h2B: begin
                st_q.push_back(3); rd_q.push_back(1'($urandom));
                for (int i = 0; i < sm; i++) begin
                    st_q.push_back(op == 6'h23 ? 4 : 6); rd_q.push_back(0);
                end
                st_q.push_back(op == 6'h23 ? 4 : 6); rd_q.push_back(1);
                if (op == 6'h23) begin st_q.push_back(5); rd_q.push_back(1'($urandom)); end
            end
            6'h08: begin
                st_q.push_back(3); rd_q.push_back(1'($urandom));
                st_q.push_back(8); rd_q.push_back(1'($urandom));
            end
            6'h04: begin st_q.push_back(9); rd_q.push_back(1'($urandom)); end
            6'h02: begin st_q.push_back(10); rd_q.push_back(1'($urandom)); end
            default: begin trap = 1; st_q.push_back(11); rd_q.push_back(1'($urandom)); end
        endcase
        foreach (st_q[i]) cycle(st_q[i], rd_q[i], op, fn, z);
        if (!trap) exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    task automatic do_reset();
        rst = 1;
        ready = 1;
        @(negedge clk);
        check("ctrl_in_reset", int'(ctrl_vec), 0);
        @(posedge clk);
        #1;
        rst = 0;
        exp_cnt = 0;
        check("rst_state", int'(state), 0);
        check("rst_illegal", int'(illegal), 0);
        check("rst_cnt", int'(cnt), 0);
    endtask

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        int         cycles;
        logic [3:0] alu_c2;   // o_c_aluOp in the third cycle
        logic       pcw_last; // o_c_pcWrite in the retiring cycle
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [5:0] legal_fn[5];
        int   cyc;
        logic [3:0] alu_seen;
        logic       pcw_seen;

        legal_fn = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        vecs = '{
            '{6'h00, 6'h20, 1'b0, 4, 4'b0010, 1'b0},
            '{6'h00, 6'h22, 1'b0, 4, 4'b0110, 1'b0},
            '{6'h00, 6'h24, 1'b0, 4, 4'b0000, 1'b0},
            '{6'h00, 6'h25, 1'b0, 4, 4'b0001, 1'b0},
            '{6'h00, 6'h2A, 1'b0, 4, 4'b0111, 1'b0},
            '{6'h23, 6'h00, 1'b0, 5, 4'b0010, 1'b0},
            '{6'h2B, 6'h00, 1'b0, 4, 4'b0010, 1'b0},
            '{6'h08, 6'h00, 1'b0, 4, 4'b0010, 1'b0},
            '{6'h04, 6'h00, 1'b1, 3, 4'b0110, 1'b1},
            '{6'h04, 6'h00, 1'b0, 3, 4'b0110, 1'b0},
            '{6'h02, 6'h00, 1'b0, 3, 4'b0000, 1'b1}
        };

        rst = 1; opcode = 0; funct = 0; zero = 0; ready = 1;
        @(posedge clk);
        #1;
        do_reset();

        // Table: latency and key controls measured from the DUT with ready=1.
        foreach (vecs[v]) begin
            cyc = 0; alu_seen = 4'hF; pcw_seen = 1'b0;
            do begin
                opcode = vecs[v].op; funct = vecs[v].fn; zero = vecs[v].z; ready = 1;
                @(negedge clk);
                if (cyc == 2) alu_seen = alu_op;
                pcw_seen = pc_write;
                cyc++;
                @(posedge clk);
                #1;
            end while (state != 4'd0 && cyc < 20);
            exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
            check("tbl_cycles", cyc, vecs[v].cycles);
            check("tbl_aluop", int'(alu_seen), int'(vecs[v].alu_c2));
            check("tbl_pcwrite", int'(pcw_seen), int'(vecs[v].pcw_last));
            check("tbl_cnt", int'(cnt), exp_cnt);
        end

        // R-type add from a fresh reset, then lw with a two-cycle MEM_RD stall.
        do_reset();
        run_instr(6'h00, 6'h20, 1'b0, 0, 0);
        check("add_retired", int'(cnt), 1);
        run_instr(6'h23, 6'h00, 1'b0, 0, 2);

        // Illegal funct: trap is absorbing and sticky until reset.
        run_instr(6'h00, 6'h3F, 1'b0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(11, 1'($urandom), 6'h00, 6'h20, 1'b0);
        do_reset();

        // Randomized legal instruction stream with random stalls.
        for (int n = 0; n < 200; n++) begin
            logic [5:0] op, fn;
            case ($urandom_range(0, 5))
                0: op = 6'h00;
                1: op = 6'h23;
                2: op = 6'h2B;
                3: op = 6'h08;
                4: op = 6'h04;
                default: op = 6'h02;
            endcase
            fn = (op == 6'h00) ? legal_fn[$urandom_range(0, 4)] : 6'($urandom);
            run_instr(op, fn, 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset in the middle of a stalled sw store.
        cycle(0, 1'b1, 6'h2B, 6'h00, 1'b0);
        cycle(1, 1'b1, 6'h2B, 6'h00, 1'b0);
        cycle(3, 1'b1, 6'h2B, 6'h00, 1'b0);
        cycle(6, 1'b0, 6'h2B, 6'h00, 1'b0);
        ready = 0;
        rst = 1;
        @(negedge clk);
        check("sw_rst_memwrite", int'(mem_write), 0);
        check("sw_rst_ctrl", int'(ctrl_vec), 0);
        @(posedge clk);
        #1;
        rst = 0;
        exp_cnt = 0;
        check("sw_rst_state", int'(state), 0);
        check("sw_rst_cnt", int'(cnt), 0);

        // Counter wrap: 16 jumps bring a 4-bit counter back to 0.
        for (int n = 0; n < 16; n++) run_instr(6'h02, 6'h00, 1'b0, $urandom_range(0, 2), 0);
        check("cnt_wrap", int'(cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
